// File: rtl/shared_counters_pkg.sv
// Shared encodings for the counter-bank host: bank commands, host ops, host FSM states.
package shared_counters_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE    = 3'd0,
        CMD_INC     = 3'd1,
        CMD_NEW     = 3'd2,
        CMD_DEALLOC = 3'd3,
        CMD_LOAD    = 3'd4,
        CMD_READ    = 3'd5
    } bank_cmd_e;

    typedef enum logic [2:0] {
        OP_ALLOC   = 3'd0,
        OP_INC     = 3'd1,
        OP_DEALLOC = 3'd2,
        OP_LOAD    = 3'd3,
        OP_READ    = 3'd4
    } host_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_LD_GAP = 3'd2,
        ST_READ   = 3'd3,
        ST_RESP   = 3'd4
    } host_state_e;

endpackage

// File: rtl/shared_counters_host_counter_read_assembler.sv
// Collects the bank's serial G-bit read stream into one W-bit word and flags the final beat.
module counter_read_assembler #(
    parameter int unsigned N = 10,
    parameter int unsigned G = 4,
    parameter int unsigned W = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_sample,
    input  logic [$clog2(N)-1:0]   i_id,
    input  logic [G-1:0]           i_rd_data,
    input  logic                   i_rd_valid,
    input  logic                   i_rd_last,
    output logic [$clog2(N):0]     o_beats,
    output logic [$clog2(N):0]     o_beats_nxt_c,
    output logic [W-1:0]           o_acc_nxt_c,
    output logic                   o_final_c,
    output logic                   o_abort_c
);

    localparam int unsigned SZW  = $clog2(N) + 1;
    localparam int unsigned BMAX = W / G;

    logic [SZW-1:0] r_beat;
    logic [W-1:0]   r_acc;
    logic [31:0]    w_remain;
    logic [31:0]    w_limit;
    logic [31:0]    w_beat_inc;
    logic           w_top;
    logic           w_take;

    // Beats available from this id, capped by what fits in the word.
    assign w_remain   = 32'(N) - 32'(i_id);
    assign w_limit    = (w_remain < 32'(BMAX)) ? w_remain : 32'(BMAX);
    assign w_beat_inc = 32'(r_beat) + 32'd1;
    // The bank leaves rd_last stale at the last physical subcounter.
    assign w_top      = (32'(i_id) + 32'(r_beat)) == 32'(N - 1);
    assign w_take     = i_sample && i_rd_valid;

    assign o_beats       = r_beat;
    assign o_beats_nxt_c = r_beat + SZW'(1);
    assign o_acc_nxt_c   = r_acc | (W'(i_rd_data) << (32'(r_beat) * G));
    assign o_final_c     = w_take && ((i_rd_last && !w_top) || (w_beat_inc == w_limit));
    assign o_abort_c     = i_sample && !i_rd_valid;

    // Beat counter and accumulator; cleared at command issue, advanced per valid beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_beat <= '0;
            r_acc  <= '0;
        end else if (w_take) begin
            r_beat <= o_beats_nxt_c;
            r_acc  <= o_acc_nxt_c;
        end
    end

endmodule

// File: rtl/shared_counters_host.sv
// Host command sequencer for the shared counter bank: one request in, bank command sequence out, one response back.
module shared_counters_host
    import shared_counters_pkg::*;
#(
    parameter int unsigned N = 10,
    parameter int unsigned G = 4,
    parameter int unsigned W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [$clog2(N)-1:0]   req_id,
    input  logic [$clog2(N):0]     req_size,
    input  logic [W-1:0]           req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_ok,
    output logic [$clog2(N):0]     rsp_id,
    output logic [W-1:0]           rsp_data,
    output logic [$clog2(N):0]     rsp_beats,
    output logic [2:0]             cmd_out,
    output logic [$clog2(N)-1:0]   cmd_id,
    output logic [31:0]            cmd_size,
    output logic [W-1:0]           ld_data,
    output logic                   ld_valid,
    input  logic [$clog2(N):0]     alloc_id,
    input  logic                   alloc_valid,
    input  logic [G-1:0]           rd_data,
    input  logic                   rd_valid,
    input  logic                   rd_last
);

    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned SZW = IDW + 1;

    host_state_e      r_state;
    logic [2:0]       r_op;
    logic [IDW-1:0]   r_id;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_rsp_ok;
    logic [SZW-1:0]   r_rsp_id;
    logic [W-1:0]     r_rsp_data;
    logic [SZW-1:0]   r_rsp_beats;
    bank_cmd_e        r_cmd;
    logic [IDW-1:0]   r_cmd_id;
    logic [31:0]      r_cmd_size;
    logic [W-1:0]     r_ld_data;
    logic             r_ld_valid;

    logic             w_hs;
    logic             w_req_ok;
    logic             w_in_read;
    logic [SZW-1:0]   w_beats;
    logic [SZW-1:0]   w_beats_nxt;
    logic [W-1:0]     w_acc_nxt;
    logic             w_final;
    logic             w_abort;

    assign w_hs      = req_valid && r_req_ready;
    assign w_in_read = (r_state == ST_READ);

    counter_read_assembler #(
        .N (N),
        .G (G),
        .W (W)
    ) u_asm (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_start       (r_state == ST_EXEC),
        .i_sample      (w_in_read),
        .i_id          (r_id),
        .i_rd_data     (rd_data),
        .i_rd_valid    (rd_valid),
        .i_rd_last     (rd_last),
        .o_beats       (w_beats),
        .o_beats_nxt_c (w_beats_nxt),
        .o_acc_nxt_c   (w_acc_nxt),
        .o_final_c     (w_final),
        .o_abort_c     (w_abort)
    );

    // Request legality: id in range, ALLOC size 1..N, known op.
    always_comb begin
        w_req_ok = 1'b1;
        if (32'(req_id) >= N) begin
            w_req_ok = 1'b0;
        end
        case (req_op)
            OP_ALLOC: begin
                if ((req_size == '0) || (32'(req_size) > N)) begin
                    w_req_ok = 1'b0;
                end
            end
            OP_INC, OP_DEALLOC, OP_LOAD, OP_READ: ;
            default: w_req_ok = 1'b0;
        endcase
    end

    // Read command drops to idle in the final/aborting beat so the bank never walks past the counter.
    always_comb begin
        cmd_out = 3'(r_cmd);
        if (w_in_read && (w_final || w_abort)) begin
            cmd_out = 3'(CMD_IDLE);
        end
    end

    // Host FSM with registered bank-side and response-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_id        <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_ok    <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_beats <= '0;
            r_cmd       <= CMD_IDLE;
            r_cmd_id    <= '0;
            r_cmd_size  <= '0;
            r_ld_data   <= '0;
            r_ld_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_req_ready <= 1'b0;
                        r_op        <= req_op;
                        r_id        <= req_id;
                        if (!w_req_ok) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_ok    <= 1'b0;
                            r_rsp_id    <= SZW'(req_id);
                            r_rsp_data  <= '0;
                            r_rsp_beats <= '0;
                        end else begin
                            r_state    <= ST_EXEC;
                            r_cmd_id   <= req_id;
                            r_cmd_size <= '0;
                            case (req_op)
                                OP_ALLOC: begin
                                    r_cmd      <= CMD_NEW;
                                    r_cmd_size <= 32'(req_size);
                                end
                                OP_INC:     r_cmd <= CMD_INC;
                                OP_DEALLOC: r_cmd <= CMD_DEALLOC;
                                OP_LOAD: begin
                                    r_cmd      <= CMD_LOAD;
                                    r_ld_valid <= 1'b1;
                                    r_ld_data  <= req_data;
                                end
                                default:    r_cmd <= CMD_READ;
                            endcase
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                ST_EXEC: begin
                    r_ld_valid  <= 1'b0;
                    r_rsp_id    <= SZW'(r_id);
                    r_rsp_data  <= '0;
                    r_rsp_beats <= '0;
                    case (r_op)
                        OP_ALLOC: begin
                            r_state     <= ST_RESP;
                            r_cmd       <= CMD_IDLE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_ok    <= alloc_valid;
                            r_rsp_id    <= alloc_id;
                        end
                        OP_INC, OP_DEALLOC: begin
                            r_state     <= ST_RESP;
                            r_cmd       <= CMD_IDLE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_ok    <= 1'b1;
                        end
                        OP_LOAD: begin
                            r_state <= ST_LD_GAP;
                            r_cmd   <= CMD_IDLE;
                        end
                        default: begin
                            r_state <= ST_READ;
                            r_cmd   <= CMD_READ;
                        end
                    endcase
                end

                ST_LD_GAP: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_ok    <= 1'b1;
                end

                ST_READ: begin
                    if (w_abort) begin
                        r_state     <= ST_RESP;
                        r_cmd       <= CMD_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_ok    <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_beats <= w_beats;
                    end else if (w_final) begin
                        r_state     <= ST_RESP;
                        r_cmd       <= CMD_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_ok    <= 1'b1;
                        r_rsp_data  <= w_acc_nxt;
                        r_rsp_beats <= w_beats_nxt;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_ok    <= 1'b0;
                        r_rsp_id    <= '0;
                        r_rsp_data  <= '0;
                        r_rsp_beats <= '0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd       <= CMD_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_ok    = r_rsp_ok;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_beats = r_rsp_beats;
    assign cmd_id    = r_cmd_id;
    assign cmd_size  = r_cmd_size;
    assign ld_data   = r_ld_data;
    assign ld_valid  = r_ld_valid;

endmodule

// File: doc/shared_counters_host.md
# shared_counters_host

Host-side command sequencer and read-data collector for the shared counter bank. Accepts one high-level request at a time (allocate, increment, deallocate, load, read) on a valid/ready port and drives the bank's 3-bit command bus, id, size and load-data inputs with the required cycle sequencing. Reassembles the bank's serial G-bit read stream (`rdata`/`valid`/`last`) into one W-bit word. Returns one response per request. Sits between the bank and the system bus adapter.

## Interface
Reset: one clock; reset is asynchronous and active-low.
- `N`, 10: subcounters in the bank.
- `G`, 4: bits per subcounter.
- `W`, 64: load/read word width; N*G need not be ≤ W, since reads are capped at W/G beats.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `req_valid` / `req_ready`  in/out  1  request handshake
- `req_op`  in  3  0 ALLOC, 1 INC, 2 DEALLOC, 3 LOAD, 4 READ; other codes are invalid
- `req_id`  in  $clog2(N)  target counter id
- `req_size`  in  $clog2(N)+1  ALLOC size, in subcounters
- `req_data`  in  W  LOAD value
- `rsp_valid` / `rsp_ready`  out/in  1  response handshake
- `rsp_ok`  out  1  request succeeded
- `rsp_id`  out  $clog2(N)+1  allocated id for ALLOC; otherwise `req_id`
- `rsp_data`  out  W  assembled READ value, zero-extended; 0 for other ops
- `rsp_beats`  out  $clog2(N)+1  READ beats collected
- `cmd_out`  out  3  bank command: 000 idle, 001 inc, 010 new_counter, 011 dealloc, 100 load, 101 read
- `cmd_id`  out  $clog2(N)  bank id
- `cmd_size`  out  32  bank new_counter size
- `ld_data`, `ld_valid`  out  W, 1  bank load data and load strobe
- `alloc_id`, `alloc_valid`  in  $clog2(N)+1, 1  bank allocation result; combinational in the new_counter cycle
- `rd_data`, `rd_valid`, `rd_last`  in  G, 1, 1  bank read stream

## Operation
- States: IDLE, EXEC, LD_GAP, READ, RESP.
- **IDLE**
  - `req_ready`=1.
  - On handshake, latch op/id/size/data.
  - Invalid request (`id`≥N, ALLOC size 0 or >N, unknown op): go to RESP with `rsp_ok`=0. Nothing is issued to the bank.
  - Valid request: go to EXEC.
- **EXEC** (one cycle; drives the op's command with `cmd_id`/`cmd_size`)
  - ALLOC: sample `alloc_valid`/`alloc_id` this cycle. `rsp_ok`=`alloc_valid`. Go to RESP.
  - INC, DEALLOC: go to RESP with `rsp_ok`=1.
  - LOAD: `ld_valid`=1, `ld_data`=data. Go to LD_GAP.
  - READ: go to READ; beat counter=0, accumulator=0.
- **LD_GAP**: `cmd_out`=idle for one cycle while the bank applies the registered load. Then go to RESP with `rsp_ok`=1.
- **READ** (`cmd_out`=read)
  - Each cycle, sample the stream.
  - `rd_valid`=0: go to RESP with `rsp_ok`=0 and `rsp_data`=0.
  - `rd_valid`=1: write `rd_data` into accumulator bits [beat*G +: G]; increment beat.
  - Final beat: `rd_last`=1, or beat+1 = min(N−id, W/G). `rd_last` is ignored at the top index, where the bank leaves it stale.
  - On the final beat, `cmd_out` is combinationally idle in that same cycle, so the bank never indexes past N−1. Go to RESP with `rsp_ok`=1.
- **RESP**
  - `rsp_valid`=1; all `rsp_*` held stable; `cmd_out`=idle.
  - On `rsp_ready`, go to IDLE.

## Timing
- Reset values: `req_ready`=0 during reset, then 1 on the first cycle after release.
  - `rsp_valid`=0, `rsp_*`=0, `cmd_out`=000, `cmd_id`=0, `cmd_size`=0, `ld_valid`=0, `ld_data`=0.
  - State returns to IDLE.
- Reset mid-operation aborts immediately; no response is produced. `cmd_out` drops to idle asynchronously.
- Outputs are Moore from state, except READ-state `cmd_out`, which also depends on `rd_valid`/`rd_last`.
- Latencies from the request handshake cycle to `rsp_valid`:
  - INC, DEALLOC, ALLOC: 2 cycles.
  - LOAD: 3 cycles.
  - READ: 2 + beats cycles. The first beat arrives the cycle after EXEC.
  - Invalid request: 1 cycle.
- No new request is accepted while busy; one outstanding request at most.
- Back-to-back: RESP→IDLE costs one cycle; the bank sees at least one idle cycle between commands.

## Structure
- Shared package `shared_counters_pkg`:
  - bank command encoding enum (idle…read);
  - host op enum;
  - host state enum.
- One sub-module: `counter_read_assembler` (beat counter, shift-in accumulator, final-beat detect). The FSM stays in the top.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, with `req_valid`=1 → no handshake, `cmd_out`=000, `rsp_valid`=0; `req_ready`=1 one cycle after release.
- ALLOC size 3 on an empty bank → one cycle of `cmd_out`=010 with `cmd_size`=3; `rsp_ok`=1, `rsp_id`=0. A second ALLOC size 2 → `rsp_id`=3.
- LOAD id 0 data 0x321, then READ id 0:
  - LOAD: `ld_valid` for exactly 1 cycle, followed by 1 idle cycle.
  - READ: beats 1, 2, 3; `rsp_data`=0x321, `rsp_beats`=3; `cmd_out` idle in the third-beat cycle.
- INC id 3 seventeen times, then READ id 3 → `rsp_data`=0x11, `rsp_beats`=2, `rsp_ok`=1.
- READ of an unallocated id 7 (first beat `rd_valid`=0) → `rsp_ok`=0, `rsp_data`=0.
- Invalid requests:
  - ALLOC size 0 and READ id 10 (N=10) → `rsp_ok`=0 after 1 cycle; `cmd_out` stays 000.
  - Hold `rsp_ready`=0 for 5 cycles → `rsp_*` stable, `req_ready`=0.
